qft_phase_rotator_pipe: RTL and testbench

- Pipelined, parametrised complex phase rotator for the QFT datapath: out = in × (cos θ + j·sin θ), or in × (cos θ − j·sin θ) in conjugate (inverse-QFT) mode.
- Sits between the amplitude source and the butterfly/accumulate stage.
- Replaces the fixed-width combinational multiplier with a 3-stage registered pipeline that adds:
  - valid/ready flow control,
  - round-half-up rounding and output saturation,
  - per-sample conjugate select,
  - a sideband tag passthrough.

---
 rtl/qft_phase_rotator_pipe_pkg.sv | 70 +++++++
 rtl/qft_phase_rotator_pipe_if.sv | 45 ++++
 rtl/qft_round_sat.sv | 29 ++
 rtl/qft_phase_rotator_pipe.sv | 168 ++++++++++++++++
 tb/tb_qft_phase_rotator_pipe.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/qft_phase_rotator_pipe_pkg.sv
// ---------------------------------------------------------------------------
// qft_pkg
// Shared fixed-point helpers for the QFT phase rotator.
//   * Q-format width helpers (coefficient fraction bits, output width, shift)
//   * default-width localparams and named twiddle constants for COEF_W = 12
//   * round-half-up + saturate function used by qft_round_sat
// No ports (package).
// ---------------------------------------------------------------------------
package qft_pkg;

    // Default datapath widths.
    localparam int DATA_W_DEF   = 8;
    localparam int COEF_W_DEF   = 12;
    localparam int OUT_FRAC_DEF = 5;
    localparam int TAG_W_DEF    = 4;

    // Coefficients are Q2.(COEF_W-2): two integer bits including sign.
    function automatic int coef_frac_f(input int coef_w);
        return coef_w - 2;
    endfunction

    // One extra integer bit absorbs the |cos|+|sin| growth of the rotation.
    function automatic int out_w_f(input int data_w, input int out_frac);
        return data_w + 1 + out_frac;
    endfunction

    // Number of fraction bits dropped between the sums and the output.
    function automatic int sh_f(input int coef_w, input int out_frac);
        return coef_frac_f(coef_w) - out_frac;
    endfunction

    localparam int COEF_FRAC = coef_frac_f(COEF_W_DEF);
    localparam int OUT_W     = out_w_f(DATA_W_DEF, OUT_FRAC_DEF);
    localparam int SH        = sh_f(COEF_W_DEF, OUT_FRAC_DEF);

    // Twiddle constants for COEF_W = 12 (1.0 and cos(pi/4) in Q2.10).
    localparam int ONE        = 1024;
    localparam int HALF_SQRT2 = 724;

    typedef struct packed {
        logic [63:0] val;   // saturated value, sign-extended to 64 bits
        logic        sat;   // saturation was applied
    } round_sat_t;

    // Round half toward +inf, then clamp to a signed out_w-bit range.
    // Works on a 64-bit container so one function serves every width.
    function automatic round_sat_t round_sat(input logic signed [63:0] x,
                                             input int                 sh,
                                             input int                 out_w);
        logic signed [63:0] rnd;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        round_sat_t         res;
        rnd   = (sh > 0) ? ((x + (64'sd1 <<< (sh - 1))) >>> sh) : x;
        max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_w - 1));
        if (rnd > max_v) begin
            res.val = max_v;
            res.sat = 1'b1;
        end else if (rnd < min_v) begin
            res.val = min_v;
            res.sat = 1'b1;
        end else begin
            res.val = rnd;
            res.sat = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/qft_phase_rotator_pipe_if.sv
// ---------------------------------------------------------------------------
// qft_phase_rotator_pipe_if
// Sample-in / sample-out stream bundle of the phase rotator.
//   s_valid/s_ready/s_r/s_i/s_cos/s_sin/s_conj/s_tag : input stream
//   m_valid/m_ready/m_r/m_i/m_sat/m_tag              : output stream
// Modports: slave  = the rotator (consumes s_*, produces m_*)
//           master = its environment (produces s_*, consumes m_*)
// ---------------------------------------------------------------------------
interface qft_phase_rotator_pipe_if
    import qft_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int COEF_W   = COEF_W_DEF,
    parameter int OUT_FRAC = OUT_FRAC_DEF,
    parameter int TAG_W    = TAG_W_DEF
);
    localparam int OUT_W = out_w_f(DATA_W, OUT_FRAC);

    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_r;
    logic signed [DATA_W-1:0] s_i;
    logic signed [COEF_W-1:0] s_cos;
    logic signed [COEF_W-1:0] s_sin;
    logic                     s_conj;
    logic [TAG_W-1:0]         s_tag;

    logic                     m_valid;
    logic                     m_ready;
    logic signed [OUT_W-1:0]  m_r;
    logic signed [OUT_W-1:0]  m_i;
    logic                     m_sat;
    logic [TAG_W-1:0]         m_tag;

    modport slave (
        input  s_valid, s_r, s_i, s_cos, s_sin, s_conj, s_tag, m_ready,
        output s_ready, m_valid, m_r, m_i, m_sat, m_tag
    );

    modport master (
        output s_valid, s_r, s_i, s_cos, s_sin, s_conj, s_tag, m_ready,
        input  s_ready, m_valid, m_r, m_i, m_sat, m_tag
    );

endinterface

// File: rtl/qft_round_sat.sv
// ---------------------------------------------------------------------------
// qft_round_sat
// Combinational round-half-up + saturate for one rotated component.
//   x   in  IN_W  full-precision signed sum
//   y   out OUT_W rounded, saturated result
//   sat out 1     y was clamped
// ---------------------------------------------------------------------------
module qft_round_sat
    import qft_pkg::*;
#(
    parameter int IN_W  = 22,
    parameter int SH    = 5,
    parameter int OUT_W = 14
) (
    input  logic signed [IN_W-1:0]  x,
    output logic signed [OUT_W-1:0] y,
    output logic                    sat
);
    round_sat_t res;
    logic       unused_hi;

    assign res = round_sat(64'(x), SH, OUT_W);
    assign y   = res.val[OUT_W-1:0];
    assign sat = res.sat;

    // After saturation the upper bits are only sign copies.
    assign unused_hi = ^res.val[63:OUT_W];

endmodule

// File: rtl/qft_phase_rotator_pipe.sv
// ---------------------------------------------------------------------------
// qft_phase_rotator_pipe
// 3-stage complex phase rotator: out = in * (cos +/- j sin).
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : stream bundle (slave side), see qft_phase_rotator_pipe_if
// Stage 1 registers the sample and the (optionally negated) sin, stage 2 the
// four products, stage 3 the rounded/saturated sums. Each stage moves when
// the next one is empty or moving, so bubbles collapse and a stalled output
// holds its value.
// ---------------------------------------------------------------------------
module qft_phase_rotator_pipe
    import qft_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int COEF_W   = COEF_W_DEF,
    parameter int OUT_FRAC = OUT_FRAC_DEF,
    parameter int TAG_W    = TAG_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    qft_phase_rotator_pipe_if.slave    bus
);
    localparam int OUT_W  = out_w_f(DATA_W, OUT_FRAC);
    localparam int SHIFT  = sh_f(COEF_W, OUT_FRAC);
    localparam int SIN_W  = COEF_W + 1;           // room for -(-2^(COEF_W-1))
    localparam int PROD_W = DATA_W + COEF_W + 1;
    localparam int SUM_W  = PROD_W + 1;

    // Handshake / advance terms.
    logic rdy1, rdy2, rdy3;
    logic load1, load2, load3;
    logic s_ready;

    // Stage valids.
    logic v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;

    // Stage 1 state.
    logic signed [DATA_W-1:0] r1_d, r1_q, i1_d, i1_q;
    logic signed [COEF_W-1:0] cos1_d, cos1_q;
    logic signed [SIN_W-1:0]  sin1_d, sin1_q;
    logic [TAG_W-1:0]         tag1_d, tag1_q;
    logic signed [SIN_W-1:0]  sin_x;

    // Stage 2 state.
    logic signed [PROD_W-1:0] prc_d, prc_q, pis_d, pis_q;
    logic signed [PROD_W-1:0] pic_d, pic_q, prs_d, prs_q;
    logic [TAG_W-1:0]         tag2_d, tag2_q;
    logic signed [PROD_W-1:0] r_x, i_x, cos_x, sin_e_x;

    // Stage 3 state (drives the output port).
    logic signed [SUM_W-1:0]  re_s, im_s;
    logic signed [OUT_W-1:0]  re_rs, im_rs;
    logic                     re_sat, im_sat;
    logic signed [OUT_W-1:0]  m_r_d, m_r_q, m_i_d, m_i_q;
    logic                     m_sat_d, m_sat_q;
    logic [TAG_W-1:0]         m_tag_d, m_tag_q;

    // -------------------------------------------------------------------
    // Flow control and next-state logic
    // -------------------------------------------------------------------
    // NOTE: every always_comb output gets a value on every path (here by
    // straight-line assignment or a hold-term mux), so no latch is inferred.
    always_comb begin
        rdy3    = ~v3_q | bus.m_ready;
        rdy2    = ~v2_q | rdy3;
        rdy1    = ~v1_q | rdy2;
        s_ready = ~rst & rdy1;

        load1 = bus.s_valid & s_ready;
        load2 = v1_q & rdy2;
        load3 = v2_q & rdy3;

        v1_d = load1 | (v1_q & ~rdy2);
        v2_d = load2 | (v2_q & ~rdy3);
        v3_d = load3 | (v3_q & ~bus.m_ready);

        // Stage 1: capture the sample; negate sin at one extra bit.
        sin_x  = SIN_W'(bus.s_sin);
        r1_d   = load1 ? bus.s_r   : r1_q;
        i1_d   = load1 ? bus.s_i   : i1_q;
        cos1_d = load1 ? bus.s_cos : cos1_q;
        sin1_d = load1 ? (bus.s_conj ? -sin_x : sin_x) : sin1_q;
        tag1_d = load1 ? bus.s_tag : tag1_q;

        // Stage 2: four full-precision products.
        r_x     = PROD_W'(r1_q);
        i_x     = PROD_W'(i1_q);
        cos_x   = PROD_W'(cos1_q);
        sin_e_x = PROD_W'(sin1_q);
        prc_d   = load2 ? r_x * cos_x   : prc_q;
        pis_d   = load2 ? i_x * sin_e_x : pis_q;
        pic_d   = load2 ? i_x * cos_x   : pic_q;
        prs_d   = load2 ? r_x * sin_e_x : prs_q;
        tag2_d  = load2 ? tag1_q : tag2_q;

        // Stage 3: complex sum, then round/saturate below.
        re_s    = SUM_W'(prc_q) - SUM_W'(pis_q);
        im_s    = SUM_W'(pic_q) + SUM_W'(prs_q);
        m_r_d   = load3 ? re_rs              : m_r_q;
        m_i_d   = load3 ? im_rs              : m_i_q;
        m_sat_d = load3 ? (re_sat | im_sat)  : m_sat_q;
        m_tag_d = load3 ? tag2_q             : m_tag_q;
    end

    qft_round_sat #(.IN_W(SUM_W), .SH(SHIFT), .OUT_W(OUT_W)) u_rs_re (
        .x   (re_s),
        .y   (re_rs),
        .sat (re_sat)
    );

    qft_round_sat #(.IN_W(SUM_W), .SH(SHIFT), .OUT_W(OUT_W)) u_rs_im (
        .x   (im_s),
        .y   (im_rs),
        .sat (im_sat)
    );

    // -------------------------------------------------------------------
    // Control and output registers (reset)
    // -------------------------------------------------------------------
    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            m_r_q   <= '0;
            m_i_q   <= '0;
            m_sat_q <= 1'b0;
            m_tag_q <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            m_r_q   <= m_r_d;
            m_i_q   <= m_i_d;
            m_sat_q <= m_sat_d;
            m_tag_q <= m_tag_d;
        end
    end

    // -------------------------------------------------------------------
    // Internal datapath registers (no reset)
    // -------------------------------------------------------------------
    // NOTE: intermediate data needs no reset; its stage valid already
    // qualifies it, and leaving it out keeps reset fan-out small.
    always_ff @(posedge clk) begin
        r1_q   <= r1_d;
        i1_q   <= i1_d;
        cos1_q <= cos1_d;
        sin1_q <= sin1_d;
        tag1_q <= tag1_d;
        prc_q  <= prc_d;
        pis_q  <= pis_d;
        pic_q  <= pic_d;
        prs_q  <= prs_d;
        tag2_q <= tag2_d;
    end

    assign bus.s_ready = s_ready;
    assign bus.m_valid = v3_q;
    assign bus.m_r     = m_r_q;
    assign bus.m_i     = m_i_q;
    assign bus.m_sat   = m_sat_q;
    assign bus.m_tag   = m_tag_q;

endmodule

// File: tb/tb_qft_phase_rotator_pipe.sv
// ---------------------------------------------------------------------------
// tb_qft_phase_rotator_pipe
// Directed vectors with hand-computed results for the phase rotator. The
// driver pushes the expected response when a sample is accepted; an
// independent monitor pops and compares whenever an output handshake occurs.
// ---------------------------------------------------------------------------
module tb_qft_phase_rotator_pipe;
    import qft_pkg::*;

    localparam int DATA_W   = 8;
    localparam int COEF_W   = 12;
    localparam int OUT_FRAC = 5;
    localparam int TAG_W    = 4;
    localparam int OW       = DATA_W + 1 + OUT_FRAC;

    typedef struct {
        logic signed [OW-1:0] r;
        logic signed [OW-1:0] i;
        logic                 sat;
        logic [TAG_W-1:0]     tag;
        int                   hs_cyc;
        bit                   chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    bit   bp_en = 1'b0;
    int   bp_base = 0;
    bit   saw_stall = 1'b0;

    qft_phase_rotator_pipe_if #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_FRAC(OUT_FRAC), .TAG_W(TAG_W)
    ) bus ();

    qft_phase_rotator_pipe #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_FRAC(OUT_FRAC), .TAG_W(TAG_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present one sample from the next falling edge until it is accepted.
    task automatic send(input int r, input int i, input int c, input int s,
                        input bit conj, input int tag, input int er,
                        input int ei, input bit esat, input bit lat);
        exp_t e;
        int   n;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_r     = DATA_W'(r);
        bus.s_i     = DATA_W'(i);
        bus.s_cos   = COEF_W'(c);
        bus.s_sin   = COEF_W'(s);
        bus.s_conj  = conj;
        bus.s_tag   = TAG_W'(tag);
        #1;
        n = 0;
        while (bus.s_ready !== 1'b1 && n < 50) begin
            saw_stall = 1'b1;
            n++;
            @(negedge clk);
            #1;
        end
        if (n >= 50) begin
            check("s_ready_timeout", 64'(bus.s_ready), 1);
        end else begin
            e.r       = OW'(er);
            e.i       = OW'(ei);
            e.sat     = esat;
            e.tag     = TAG_W'(tag);
            e.hs_cyc  = cyc;
            e.chk_lat = lat;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int limit, output int done);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk);
            #3;
            n++;
        end
        done = cyc;
        if (sb.size() != 0) begin
            check(name, sb.size(), 0);
            sb.delete();
        end
    endtask

    // Downstream ready: low for stream cycles 4..7 of the backpressure test.
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus.m_ready = !(bp_en && cyc >= bp_base + 4 && cyc <= bp_base + 7);
        end
    end

    // Monitor / scoreboard.
    initial begin
        exp_t        e;
        logic        hold_q;
        logic [63:0] held;
        hold_q = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            #2;
            if (bus.m_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_m_valid", 64'(bus.m_valid), 0);
                end else begin
                    if (hold_q)
                        check("stall_hold", 64'({bus.m_r, bus.m_i, bus.m_sat, bus.m_tag}), held);
                    else if (sb[0].chk_lat)
                        check("latency", cyc - sb[0].hs_cyc, 3);
                    if (bus.m_ready === 1'b1) begin
                        e = sb.pop_front();
                        check("m_r", bus.m_r, e.r);
                        check("m_i", bus.m_i, e.i);
                        check("m_sat", 64'(bus.m_sat), 64'(e.sat));
                        check("m_tag", 64'(bus.m_tag), 64'(e.tag));
                    end
                end
            end else if (hold_q) begin
                check("stall_valid", 64'(bus.m_valid), 1);
            end
            hold_q = (bus.m_valid === 1'b1) && (bus.m_ready === 1'b0);
            held   = 64'({bus.m_r, bus.m_i, bus.m_sat, bus.m_tag});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    // Stimulus.
    initial begin
        int done;
        bus.s_valid = 1'b0;
        bus.s_r     = '0;
        bus.s_i     = '0;
        bus.s_cos   = '0;
        bus.s_sin   = '0;
        bus.s_conj  = 1'b0;
        bus.s_tag   = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_m_valid", 64'(bus.m_valid), 0);
        check("rst_m_r", bus.m_r, 0);
        check("rst_m_i", bus.m_i, 0);
        check("rst_m_sat", 64'(bus.m_sat), 0);
        check("rst_m_tag", 64'(bus.m_tag), 0);
        check("rst_s_ready", 64'(bus.s_ready), 0);
        rst = 1'b0;
        #1;
        check("post_rst_s_ready", 64'(bus.s_ready), 1);

        // Identity, 90 deg and its conjugate.
        send(100, -50, ONE, 0, 1'b0, 1, 3200, -1600, 1'b0, 1'b1);
        send(3, 7, 0, ONE, 1'b0, 2, -224, 96, 1'b0, 1'b1);
        send(3, 7, 0, ONE, 1'b1, 3, 224, -96, 1'b0, 1'b1);
        // 45 deg with rounding; half-LSB ties go toward +inf.
        send(127, 127, HALF_SQRT2, HALF_SQRT2, 1'b0, 4, 0, 5747, 1'b0, 1'b1);
        send(1, 0, 16, 0, 1'b0, 5, 1, 0, 1'b0, 1'b1);
        send(1, 0, -16, 0, 1'b0, 6, 0, 0, 1'b0, 1'b1);
        send(1, 0, -48, 0, 1'b0, 7, -1, 0, 1'b0, 1'b1);
        // Saturation, conjugate of the most negative sin, negative clamp.
        send(-128, -128, -2048, -2048, 1'b0, 8, 0, 8191, 1'b1, 1'b1);
        send(-128, -128, -2048, -2048, 1'b1, 9, 8191, 0, 1'b1, 1'b1);
        send(127, -128, -2048, -2048, 1'b0, 10, -8192, 64, 1'b1, 1'b1);
        idle();
        drain("directed_drain", 40, done);

        // Backpressure: 8 back-to-back samples, output stalled cycles 4..7.
        @(negedge clk);
        bp_base   = cyc + 1;
        bp_en     = 1'b1;
        saw_stall = 1'b0;
        for (int k = 0; k < 8; k++) begin
            int r, i;
            r = 10 * k - 35;
            i = 20 - 3 * k;
            if (k % 2 == 0)
                send(r, i, 0, ONE, 1'b0, k, -i * 32, r * 32, 1'b0, (k < 2 || k >= 4));
            else
                send(r, i, 0, ONE, 1'b1, k, i * 32, -r * 32, 1'b0, (k < 2 || k >= 4));
        end
        idle();
        drain("bp_drain", 40, done);
        check("bp_s_ready_dropped", 64'(saw_stall), 1);
        check("bp_last_out_cycle", done - bp_base, 14);
        bp_en = 1'b0;

        // Reset mid-stream with two samples in flight.
        send(50, 20, ONE, 0, 1'b0, 11, 1600, 640, 1'b0, 1'b1);
        send(-40, 10, ONE, 0, 1'b0, 12, -1280, 320, 1'b0, 1'b1);
        @(negedge clk);
        bus.s_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        #1;
        check("midrst_s_ready", 64'(bus.s_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_m_valid", 64'(bus.m_valid), 0);
        check("midrst_m_r", bus.m_r, 0);
        check("midrst_m_i", bus.m_i, 0);
        check("midrst_m_sat", 64'(bus.m_sat), 0);
        check("midrst_m_tag", 64'(bus.m_tag), 0);
        check("midrst_s_ready_after", 64'(bus.s_ready), 1);
        send(5, -6, 0, ONE, 1'b0, 13, 192, 160, 1'b0, 1'b1);
        idle();
        drain("midrst_drain", 40, done);
        repeat (6) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
